dice_roller: RTL and testbench

- Parametrised successor to the combinational eight_dice pip decoder: a clocked multi-die roller driving NUM_DICE 3x3 (nine-segment) LED pip grids.
- Holding `roll` spins all dice. On release, the dice coast for a fixed number of ticks, then settle.
- A free-running LFSR varies each die's step size, so results depend on press timing.
- Sits between a debounced push-button and the LED grid drivers.

---
 rtl/dice_roller.sv | 144 ++++++++++++++
 tb/tb_dice_roller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// dice_roller: clocked multi-die roller driving 3x3 LED pip grids, with LFSR-varied stepping.
// Optional registered `sum` output is enabled by defining DICE_ROLLER_SUM_EN.
module dice_roller #(
   parameter int unsigned NUM_DICE   = 2,
   parameter int unsigned MAX_FACE   = 6,
   parameter int unsigned TICK_DIV   = 1000000,
   parameter int unsigned ROLL_TICKS = 16,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  roll,
   output logic                  busy,
   output logic                  done,
   output logic [NUM_DICE*3-1:0] value,
   output logic [NUM_DICE*9-1:0] out
`ifdef DICE_ROLLER_SUM_EN
   ,
   output logic [$clog2(NUM_DICE*MAX_FACE+1)-1:0] sum
`endif
);

   localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CoastW = $clog2(ROLL_TICKS + 1);
   localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
   localparam logic [CoastW-1:0] CoastLoad = CoastW'(ROLL_TICKS);

   typedef enum logic [1:0] {StIdle, StRolling, StCoast} state_e;

   state_e                   state_q;
   logic [15:0]              lfsr_q;
   logic [TickW-1:0]         tick_cnt_q;
   logic [CoastW-1:0]        coast_cnt_q;
   logic [NUM_DICE-1:0][2:0] val_q;
   logic [NUM_DICE-1:0][2:0] val_step;
   logic [NUM_DICE-1:0][2:0] val_seed;
   logic                     busy_q;
   logic                     done_q;
   logic                     tick;
   logic                     settle;

   function automatic logic [2:0] advance(input logic [2:0] v, input logic extra);
      logic [3:0] s;
      s = {1'b0, v} + 4'd1 + {3'd0, extra};
      if (s > 4'(MAX_FACE)) s = s - 4'(MAX_FACE);
      return s[2:0];
   endfunction

   assign tick   = (tick_cnt_q == TickLast);
   assign settle = (state_q == StCoast) && tick && (coast_cnt_q == CoastW'(1));

   // val_step: every die advanced by one tick; val_seed: blank dice forced to face 1.
   always_comb begin
      val_step = '0;
      val_seed = '0;
      for (int i = 0; i < NUM_DICE; i++) begin
         val_step[i] = advance(val_q[i], lfsr_q[i]);
         val_seed[i] = (val_q[i] == 3'd0) ? 3'd1 : val_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         lfsr_q      <= SEED;
         tick_cnt_q  <= '0;
         coast_cnt_q <= '0;
         val_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         done_q <= 1'b0;
         if (state_q != StIdle) tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
         unique case (state_q)
            StIdle: begin
               if (roll) begin
                  state_q    <= StRolling;
                  busy_q     <= 1'b1;
                  tick_cnt_q <= '0;
                  val_q      <= val_seed;
               end
            end
            StRolling: begin
               if (tick) val_q <= val_step;
               if (!roll) begin
                  state_q     <= StCoast;
                  coast_cnt_q <= CoastLoad;
               end
            end
            StCoast: begin
               // roll is deliberately ignored here so a coast always runs to completion
               if (tick) begin
                  val_q       <= val_step;
                  coast_cnt_q <= coast_cnt_q - CoastW'(1);
                  if (coast_cnt_q == CoastW'(1)) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Pip layout: bit 8 top-left .. bit 0 bottom-right; centre pip shows odd faces.
   always_comb begin
      out = '0;
      for (int i = 0; i < NUM_DICE; i++) begin
         out[9*i +: 9] = {val_q[i] >= 3'd2, val_q[i] >= 3'd6, val_q[i] >= 3'd4,
                          1'b0, val_q[i][0], 1'b0,
                          val_q[i] >= 3'd4, val_q[i] >= 3'd6, val_q[i] >= 3'd2};
      end
   end

   assign value = val_q;
   assign busy  = busy_q;
   assign done  = done_q;

`ifdef DICE_ROLLER_SUM_EN
   localparam int unsigned SumW = $clog2(NUM_DICE*MAX_FACE+1);

   logic [SumW-1:0] sum_q;
   logic [SumW-1:0] sum_c;

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NUM_DICE; i++) sum_c = sum_c + SumW'(val_step[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (settle) begin
         sum_q <= sum_c;
      end
   end

   assign sum = sum_q;
`endif

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: stimulus predicts settle time and faces, a monitor checks them.
module tb_dice_roller;

   localparam int unsigned NUM_DICE   = 2;
   localparam int unsigned MAX_FACE   = 6;
   localparam int unsigned TICK_DIV   = 2;
   localparam int unsigned ROLL_TICKS = 4;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        roll  = 1'b0;
   logic        busy;
   logic        done;
   logic [5:0]  value;
   logic [17:0] out;
`ifdef DICE_ROLLER_SUM_EN
   logic [3:0]  sum;
   logic [3:0]  last_sum;
   bit          have_sum = 0;
`endif

   dice_roller #(
      .NUM_DICE  (NUM_DICE),
      .MAX_FACE  (MAX_FACE),
      .TICK_DIV  (TICK_DIV),
      .ROLL_TICKS(ROLL_TICKS),
      .SEED      (SEED)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .roll (roll),
      .busy (busy),
      .done (done),
      .value(value),
`ifdef DICE_ROLLER_SUM_EN
      .sum  (sum),
`endif
      .out  (out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] vals;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [15:0] m_lfsr;
   logic [5:0]  m_vals;
   int          m_done;
   bit          mon_en = 0;
   bit          seen [2][8];
   logic [8:0]  dec_tbl [0:7] = '{9'b000000000, 9'b000010000, 9'b100000001, 9'b100010001,
                                  9'b101000101, 9'b101010101, 9'b111000111, 9'b111010111};

   function automatic logic [15:0] lf_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [2:0] adv(input logic [2:0] v, input logic b);
      int t;
      t = (int'(v) + int'(b)) % MAX_FACE;
      return 3'(t + 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step_cyc();
      @(posedge clk);
      m_lfsr = lf_next(m_lfsr);
      cyc++;
      @(negedge clk);
   endtask

   // Raise roll before the next edge, predict the whole roll, hold roll for h edges.
   task automatic start_roll(input int h);
      exp_t        e;
      logic [15:0] l;
      logic [5:0]  v;
      bit          coasting;
      int          cnt;
      roll = 1'b1;
      l = m_lfsr;
      v = m_vals;
      for (int i = 0; i < 2; i++) if (v[3*i +: 3] == 3'd0) v[3*i +: 3] = 3'd1;
      l = lf_next(l);
      coasting = 0;
      cnt = 0;
      e.cyc = -1;
      for (int k = 1; k < 1000; k++) begin
         if (k % TICK_DIV == 0) begin
            for (int i = 0; i < 2; i++) v[3*i +: 3] = adv(v[3*i +: 3], l[i]);
            if (coasting) begin
               cnt--;
               if (cnt == 0) begin
                  e.cyc = cyc + 1 + k;
                  break;
               end
            end
         end
         if (!coasting && k >= h) begin
            coasting = 1;
            cnt = ROLL_TICKS;
         end
         l = lf_next(l);
      end
      e.vals = v;
      sb.push_back(e);
      m_vals = v;
      m_done = e.cyc;
      step_cyc();
      check("busy_rise", busy, 1);
      repeat (h - 1) step_cyc();
      roll = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc < m_done) step_cyc();
      #1;
      check("done_seen_pending", sb.size(), 0);
      sb.delete();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && rst_n) begin
         check("decode", out, {dec_tbl[value[5:3]], dec_tbl[value[2:0]]});
         if (busy) begin
            for (int i = 0; i < 2; i++)
               check("face_range", (value[3*i +: 3] >= 3'd1) && (value[3*i +: 3] <= 3'(MAX_FACE)), 1);
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("settled_value", value, e.vals);
               check("busy_at_done", busy, 0);
               for (int i = 0; i < 2; i++) seen[i][value[3*i +: 3]] = 1;
`ifdef DICE_ROLLER_SUM_EN
               check("sum", sum, 4'(value[2:0]) + 4'(value[5:3]));
               last_sum = sum;
               have_sum = 1;
`endif
            end
         end
`ifdef DICE_ROLLER_SUM_EN
         else if (busy && have_sum) check("sum_hold", sum, last_sum);
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      m_lfsr = SEED;
      m_vals = '0;
      #2 rst_n = 1'b0;
      repeat (3) step_cyc();
      check("rst_value", value, 0);
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n  = 1'b1;
      m_lfsr = SEED;
      mon_en = 1;
      for (int n = 0; n < 10; n++) begin
         step_cyc();
         check("idle_value", value, 0);
         check("idle_busy", busy, 0);
      end

      // basic roll, then values must hold
      start_roll(5);
      wait_done();
      repeat (3) step_cyc();
      check("hold_after_done", value, m_vals);
      check("idle_after_done", busy, 0);

      for (int n = 0; n < 200; n++) begin
         start_roll(1 + n % 7);
         wait_done();
         repeat (n % 3) step_cyc();
      end
      for (int i = 0; i < 2; i++)
         for (int f = 1; f <= 6; f++) check($sformatf("face_seen_d%0d_f%0d", i, f), seen[i][f], 1);

      // roll re-pressed mid-coast: same settle time, then a new roll right after done
      start_roll(3);
      repeat (1 + 2 * TICK_DIV) step_cyc();
      roll = 1'b1;
      wait_done();
      start_roll(2);
      wait_done();

      // reset during rolling
      roll = 1'b1;
      repeat (3) step_cyc();
      check("rolling_before_reset", busy, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_value", value, 0);
      check("async_rst_out", out, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      roll   = 1'b0;
      m_vals = '0;
`ifdef DICE_ROLLER_SUM_EN
      have_sum = 0;
`endif
      repeat (2) step_cyc();
      rst_n  = 1'b1;
      m_lfsr = SEED;
      #1;
      check("lfsr_seed", dut.lfsr_q, SEED);
      start_roll(4);
      wait_done();
      repeat (2) step_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
